if_stage_fetch: RTL and testbench

//  Instruction-fetch stage of the MIPS pipeline, directly upstream of instruction memory.

---
 rtl/if_stage_fetch.sv | 123 ++++++++++++
 tb/tb_if_stage_fetch.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/if_stage_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : if_stage_fetch
//  Purpose  : MIPS instruction-fetch stage.
//             - Owns the PC and presents it to a combinational instruction ROM.
//             - Captures the returned word into the IF/ID pipeline register.
//             - Handles stall, flush and branch/jump redirect.
//             - Keeps a saturating count of fetched words for debug.
//  Ports    :
//    clk             in   1      rising-edge clock
//    rst_n           in   1      asynchronous active-low reset
//    stall           in   1      hold PC and IF/ID contents
//    flush           in   1      IF/ID becomes a bubble at the next edge
//    redirect_valid  in   1      load redirect_pc into the PC
//    redirect_pc     in   32     branch/jump target
//    imem_pc         out  32     instruction memory address (= pc_q)
//    imem_instr      in   32     word returned for imem_pc in the same cycle
//    ifid_instr      out  32     registered instruction for decode
//    ifid_pc_plus4   out  32     registered PC+4 of that instruction
//    ifid_valid      out  1      1 = real fetch, 0 = bubble
//    misalign_err    out  1      sticky: a redirect target had [1:0] != 0
//    fetch_count     out  CNT_W  saturating count of valid IF/ID loads
//  Revision : 1.0  initial release
// ============================================================================
module if_stage_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic [31:0]      imem_pc,
  input  logic [31:0]      imem_instr,
  output logic [31:0]      ifid_instr,
  output logic [31:0]      ifid_pc_plus4,
  output logic             ifid_valid,
  output logic             misalign_err,
  output logic [CNT_W-1:0] fetch_count
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      ifid_instr_q, ifid_instr_d;
  logic [31:0]      ifid_pc_plus4_q, ifid_pc_plus4_d;
  logic             ifid_valid_q, ifid_valid_d;
  logic             misalign_err_q, misalign_err_d;
  logic [CNT_W-1:0] fetch_count_q, fetch_count_d;

  logic [31:0]      w_pc_plus4;
  logic             w_capture;

  // Natural 32-bit wrap takes 0xFFFF_FFFC to 0x0000_0000.
  assign w_pc_plus4 = pc_q + 32'd4;
  // A real fetch lands in IF/ID only when neither flushed nor stalled.
  assign w_capture  = !flush && !stall;

  always_comb begin
    pc_d            = pc_q;
    ifid_instr_d    = ifid_instr_q;
    ifid_pc_plus4_d = ifid_pc_plus4_q;
    ifid_valid_d    = ifid_valid_q;
    misalign_err_d  = misalign_err_q;
    fetch_count_d   = fetch_count_q;

    // Redirect wins over stall; the low bits are forced to word alignment.
    if (redirect_valid) begin
      pc_d = {redirect_pc[31:2], 2'b00};
      if (redirect_pc[1:0] != 2'b00) begin
        misalign_err_d = 1'b1;
      end
    end else if (!stall) begin
      pc_d = w_pc_plus4;
    end

    // Flush wins over stall. Redirect alone does not touch IF/ID, so the
    // word at the current PC is still captured (delay slot).
    if (flush) begin
      ifid_instr_d    = NOP_INSTR;
      ifid_pc_plus4_d = 32'h0000_0000;
      ifid_valid_d    = 1'b0;
    end else if (w_capture) begin
      ifid_instr_d    = imem_instr;
      ifid_pc_plus4_d = w_pc_plus4;
      ifid_valid_d    = 1'b1;
    end

    if (w_capture && (fetch_count_q != c_cnt_max)) begin
      fetch_count_d = fetch_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q            <= RESET_PC;
      ifid_instr_q    <= NOP_INSTR;
      ifid_pc_plus4_q <= 32'h0000_0000;
      ifid_valid_q    <= 1'b0;
      misalign_err_q  <= 1'b0;
      fetch_count_q   <= '0;
    end else begin
      pc_q            <= pc_d;
      ifid_instr_q    <= ifid_instr_d;
      ifid_pc_plus4_q <= ifid_pc_plus4_d;
      ifid_valid_q    <= ifid_valid_d;
      misalign_err_q  <= misalign_err_d;
      fetch_count_q   <= fetch_count_d;
    end
  end

  assign imem_pc       = pc_q;
  assign ifid_instr    = ifid_instr_q;
  assign ifid_pc_plus4 = ifid_pc_plus4_q;
  assign ifid_valid    = ifid_valid_q;
  assign misalign_err  = misalign_err_q;
  assign fetch_count   = fetch_count_q;

endmodule
`default_nettype wire

// File: tb/tb_if_stage_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_stage_fetch
//  Purpose  : Self-checking bench for if_stage_fetch. A main instance
//             (RESET_PC=0, CNT_W=16) and a narrow-counter instance (CNT_W=3)
//             share stimulus; a third instance starts at 0xFFFF_FFFC to
//             exercise PC wrap. Expected values come from an abstract
//             pipeline model kept in the bench.
//  Revision : 1.0  initial release
// ============================================================================
module tb_if_stage_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] rom [64];

  // main instance
  logic [31:0] imem_pc, imem_instr, ifid_instr, ifid_pc_plus4;
  logic        ifid_valid, misalign_err;
  logic [15:0] fetch_count;

  // narrow counter instance
  logic [31:0] s_imem_pc, s_imem_instr, s_ifid_instr, s_ifid_pc_plus4;
  logic        s_ifid_valid, s_misalign_err;
  logic [2:0]  s_fetch_count;

  // wrap instance
  logic        w_rst_n, w_stall, w_flush, w_redirect_valid;
  logic [31:0] w_redirect_pc;
  logic [31:0] w_imem_pc, w_imem_instr, w_ifid_instr, w_ifid_pc_plus4;
  logic        w_ifid_valid, w_misalign_err;
  logic [15:0] w_fetch_count;

  always #5 clk = ~clk;

  assign imem_instr   = rom[imem_pc[7:2]];
  assign s_imem_instr = rom[s_imem_pc[7:2]];
  assign w_imem_instr = rom[w_imem_pc[7:2]];

  if_stage_fetch #(.RESET_PC(32'h0), .NOP_INSTR(32'h0), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_pc(imem_pc), .imem_instr(imem_instr), .ifid_instr(ifid_instr),
    .ifid_pc_plus4(ifid_pc_plus4), .ifid_valid(ifid_valid),
    .misalign_err(misalign_err), .fetch_count(fetch_count));

  if_stage_fetch #(.RESET_PC(32'h0), .NOP_INSTR(32'h0), .CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_pc(s_imem_pc), .imem_instr(s_imem_instr), .ifid_instr(s_ifid_instr),
    .ifid_pc_plus4(s_ifid_pc_plus4), .ifid_valid(s_ifid_valid),
    .misalign_err(s_misalign_err), .fetch_count(s_fetch_count));

  if_stage_fetch #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0), .CNT_W(16)) dut_wrap (
    .clk(clk), .rst_n(w_rst_n), .stall(w_stall), .flush(w_flush),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .imem_pc(w_imem_pc), .imem_instr(w_imem_instr), .ifid_instr(w_ifid_instr),
    .ifid_pc_plus4(w_ifid_pc_plus4), .ifid_valid(w_ifid_valid),
    .misalign_err(w_misalign_err), .fetch_count(w_fetch_count));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: architectural view of the fetch stage.
  logic [31:0] m_pc, m_instr, m_p4;
  logic        m_valid, m_err;
  int          m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_p4 = 32'h0; m_valid = 1'b0; m_err = 1'b0; m_cnt = 0;
  endtask

  task automatic check_all(input string tag);
    int sat16, sat3;
    sat16 = (m_cnt > 65535) ? 65535 : m_cnt;
    sat3  = (m_cnt > 7) ? 7 : m_cnt;
    chk({tag, ".imem_pc"},      imem_pc,                m_pc);
    chk({tag, ".ifid_instr"},   ifid_instr,             m_instr);
    chk({tag, ".ifid_pc4"},     ifid_pc_plus4,          m_p4);
    chk({tag, ".ifid_valid"},   {31'b0, ifid_valid},    {31'b0, m_valid});
    chk({tag, ".misalign"},     {31'b0, misalign_err},  {31'b0, m_err});
    chk({tag, ".fetch_count"},  {16'b0, fetch_count},   sat16);
    chk({tag, ".sat_count"},    {29'b0, s_fetch_count}, sat3);
  endtask

  // Called shortly after an edge: apply inputs, advance the model, run one
  // edge, then check.
  task automatic cycle(input string tag, input logic s, input logic f,
                       input logic rv, input logic [31:0] rpc);
    logic [31:0] word;
    stall = s; flush = f; redirect_valid = rv; redirect_pc = rpc;
    word = rom[m_pc[7:2]];
    if (f) begin
      m_instr = 32'h0; m_p4 = 32'h0; m_valid = 1'b0;
    end else if (!s) begin
      m_instr = word; m_p4 = m_pc + 32'd4; m_valid = 1'b1; m_cnt++;
    end
    if (rv) begin
      m_pc = rpc & 32'hFFFF_FFFC;
      if (rpc[1:0] != 2'b00) m_err = 1'b1;
    end else if (!s) begin
      m_pc = m_pc + 32'd4;
    end
    @(posedge clk); #1;
    check_all(tag);
  endtask

  initial begin
    logic [31:0] rpc;
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    rom[0] = 32'h2001_000A;
    rom[1] = 32'h2002_0014;
    rom[2] = 32'h0022_1820;
    rom[5] = 32'h1021_FFFF;

    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    w_rst_n = 1'b0; w_stall = 1'b0; w_flush = 1'b0; w_redirect_valid = 1'b0; w_redirect_pc = 32'h0;
    model_reset();
    #3;
    check_all("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic sequential fetch
    cycle("t1.e1", 0, 0, 0, 0);
    chk("t1.e1.instr_lit", ifid_instr, 32'h2001_000A);
    cycle("t1.e2", 0, 0, 0, 0);
    chk("t1.e2.imem_pc_lit", imem_pc, 32'h8);

    // Stall three cycles then release
    for (int i = 0; i < 3; i++) cycle("t2.stall", 1, 0, 0, 0);
    chk("t2.hold_instr_lit", ifid_instr, 32'h2002_0014);
    cycle("t2.release", 0, 0, 0, 0);
    chk("t2.count_lit", {16'b0, fetch_count}, 32'd3);

    // Redirect + flush, then fetch at target
    cycle("t3.redir_flush", 0, 1, 1, 32'h14);
    chk("t3.pc_lit", imem_pc, 32'h14);
    cycle("t3.target", 0, 0, 0, 0);
    chk("t3.instr_lit", ifid_instr, 32'h1021_FFFF);

    // Misaligned redirect without flush (delay slot), then aligned redirect
    cycle("t4.misalign", 0, 0, 1, 32'h16);
    chk("t4.err_lit", {31'b0, misalign_err}, 32'd1);
    cycle("t4.aligned", 0, 0, 1, 32'h40);
    cycle("t4.stall_redir", 1, 0, 1, 32'h80);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      rpc = $urandom_range(0, 255);
      if (($urandom % 4) != 0) rpc[1:0] = 2'b00;
      cycle("rand", ($urandom % 4) == 0, ($urandom % 7) == 0, ($urandom % 7) == 0, rpc);
    end

    // Asynchronous reset in the middle of a stall
    cycle("t6.stall", 1, 0, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("t6.async");
    #1;
    rst_n = 1'b1;
    cycle("t6.first", 0, 0, 0, 0);
    chk("t6.instr_lit", ifid_instr, 32'h2001_000A);

    // PC wrap from 0xFFFF_FFFC
    w_rst_n = 1'b1;
    chk("t5.start_pc", w_imem_pc, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    chk("t5.wrap_pc", w_imem_pc, 32'h0);
    chk("t5.wrap_pc4", w_ifid_pc_plus4, 32'h0);
    chk("t5.wrap_instr", w_ifid_instr, rom[63]);
    @(posedge clk); #1;
    chk("t5.next_pc", w_imem_pc, 32'h4);
    chk("t5.next_instr", w_ifid_instr, rom[0]);
    chk("t5.next_pc4", w_ifid_pc_plus4, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
